// File: rtl/sfx_sequencer.sv
// sfx_sequencer: priority-arbitrated sound-effect melody sequencer driving pwm_gen note index
module sfx_sequencer #(
    parameter int TICK_CYCLES = 6_250_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] req_i,
    output logic [4:0] note_o,
    output logic       busy_o,
    output logic [1:0] active_id_o,
    output logic       done_o,
    output logic       aborted_o
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [8:0] SIL = {1'b1, 5'd31, 3'd0};
    // Melody table, one row per requester: {last, note, len}; unused slots read as a silent last step
    localparam logic [8:0] ROM [4][8] = '{
        '{{1'b0, 5'd8, 3'd1}, {1'b0, 5'd13, 3'd1}, {1'b1, 5'd20, 3'd3}, SIL, SIL, SIL, SIL, SIL},
        '{{1'b0, 5'd25, 3'd0}, {1'b0, 5'd22, 3'd0}, {1'b0, 5'd17, 3'd0}, {1'b0, 5'd13, 3'd0},
          {1'b1, 5'd8, 3'd3}, SIL, SIL, SIL},
        '{{1'b0, 5'd3, 3'd0}, {1'b0, 5'd31, 3'd0}, {1'b1, 5'd3, 3'd1}, SIL, SIL, SIL, SIL, SIL},
        '{SIL, SIL, SIL, SIL, SIL, SIL, SIL, SIL}
    };
    typedef enum logic {IDLE, PLAY} state_t;
    state_t        state_q;
    logic [2:0]    req_q, pending_q, pending_d;
    logic [2:0]    step_q, unit_q;
    logic [PW-1:0] pre_q;
    logic [4:0]    note_q;
    logic          busy_q, done_q, aborted_q;
    logic [1:0]    id_q;
    logic [2:0]    rise, ign, above;
    logic [1:0]    hi;
    logic          preempt, grant, wrap, step_end;
    // Arbitration: new requests, highest pending winner, preemption and step-boundary detection
    always_comb begin
        rise      = req_i & ~req_q;
        ign       = busy_q ? (3'b001 << id_q) : 3'b000;
        hi        = pending_q[2] ? 2'd2 : pending_q[1] ? 2'd1 : 2'd0;
        above     = (id_q == 2'd0) ? 3'b110 : (id_q == 2'd1) ? 3'b100 : 3'b000;
        preempt   = (state_q == PLAY) && |(pending_q & above);
        grant     = ((state_q == IDLE) && |pending_q) || preempt;
        pending_d = (pending_q | (rise & ~ign)) & ~(grant ? (3'b001 << hi) : 3'b000);
        wrap      = pre_q == PRE_MAX;
        step_end  = wrap && (unit_q == ROM[id_q][step_q][2:0]);
    end
    // Sequencer FSM with registered outputs; a grant or preemption overrides step advance
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            req_q     <= 3'b000;
            pending_q <= 3'b000;
            step_q    <= 3'd0;
            unit_q    <= 3'd0;
            pre_q     <= '0;
            note_q    <= 5'd31;
            busy_q    <= 1'b0;
            id_q      <= 2'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            req_q     <= req_i;
            pending_q <= pending_d;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (grant) begin
                state_q   <= PLAY;
                step_q    <= 3'd0;
                unit_q    <= 3'd0;
                pre_q     <= '0;
                note_q    <= ROM[hi][0][7:3];
                busy_q    <= 1'b1;
                id_q      <= hi;
                aborted_q <= preempt;
            end else if (state_q == PLAY) begin
                pre_q <= wrap ? '0 : pre_q + 1'b1;
                if (step_end && ROM[id_q][step_q][8]) begin
                    state_q <= IDLE;
                    note_q  <= 5'd31;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else if (step_end) begin
                    step_q <= step_q + 3'd1;
                    unit_q <= 3'd0;
                    note_q <= ROM[id_q][step_q + 3'd1][7:3];
                end else if (wrap) begin
                    unit_q <= unit_q + 3'd1;
                end
            end
        end
    end
    assign note_o      = note_q;
    assign busy_o      = busy_q;
    assign active_id_o = id_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed and randomized checks of sfx_sequencer against a countdown melody model
module tb_sfx_sequencer;
    localparam int T = 4;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [2:0] req_i = 3'b000;
    logic [4:0] note_o;
    logic       busy_o, done_o, aborted_o;
    logic [1:0] active_id_o;
    int n_chk = 0;
    int n_err = 0;
    int sn [3][5] = '{'{8, 13, 20, 0, 0}, '{25, 22, 17, 13, 8}, '{3, 31, 3, 0, 0}};
    int su [3][5] = '{'{2, 2, 4, 0, 0}, '{1, 1, 1, 1, 4}, '{1, 1, 2, 0, 0}};
    int cnt [3]   = '{3, 5, 3};
    logic [2:0] m_prev, m_pend;
    int m_id, m_step, m_left, m_note, m_busy, m_done, m_ab;

    sfx_sequencer #(.TICK_CYCLES(T)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .note_o(note_o), .busy_o(busy_o),
        .active_id_o(active_id_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int top(input logic [2:0] p);
        return p[2] ? 2 : p[1] ? 1 : 0;
    endfunction

    task automatic start(input int g);
        m_id   = g;
        m_step = 0;
        m_note = sn[g][0];
        m_left = su[g][0] * T;
        m_busy = 1;
    endtask

    // Reference: each note lasts its unit count times T cycles, counted down edge by edge
    task automatic model(input logic [2:0] r, input logic rst);
        logic [2:0] rise, np, ign;
        int g;
        if (!rst) begin
            m_prev = 0; m_pend = 0; m_busy = 0; m_id = 0; m_note = 31;
            m_done = 0; m_ab = 0; m_step = 0; m_left = 0;
            return;
        end
        rise   = r & ~m_prev;
        m_prev = r;
        ign    = (m_busy != 0) ? (3'b001 << m_id) : 3'b000;
        np     = m_pend | (rise & ~ign);
        m_done = 0;
        m_ab   = 0;
        if (m_busy == 0) begin
            if (m_pend != 0) begin
                g = top(m_pend);
                np[g] = 1'b0;
                start(g);
            end
        end else if (m_pend != 0 && top(m_pend) > m_id) begin
            g = top(m_pend);
            np[g] = 1'b0;
            start(g);
            m_ab = 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_step == cnt[m_id] - 1) begin
                    m_note = 31; m_busy = 0; m_done = 1;
                end else begin
                    m_step++;
                    m_note = sn[m_id][m_step];
                    m_left = su[m_id][m_step] * T;
                end
            end
        end
        m_pend = np;
    endtask

    task automatic cyc(input logic [2:0] r, input logic rst);
        req_i   = r;
        reset_i = rst;
        @(posedge clk_i);
        model(r, rst);
        #1;
        check("note", 32'(note_o), 32'(m_note));
        check("busy", 32'(busy_o), 32'(m_busy));
        if (m_busy != 0) check("active_id", 32'(active_id_o), 32'(m_id));
        check("done", 32'(done_o), 32'(m_done));
        check("aborted", 32'(aborted_o), 32'(m_ab));
        check("done_and_aborted", 32'(done_o & aborted_o), 32'd0);
    endtask

    initial begin
        logic [2:0] r;
        logic rst;
        for (int k = 0; k < 3; k++) cyc(3'b000, 1'b0);
        for (int k = 0; k < 50; k++) cyc(3'b000, 1'b1);
        // Swish alone with absolute timing landmarks
        cyc(3'b001, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            cyc(3'b000, 1'b1);
            if (k == 1) check("swish_first_note", 32'(note_o), 32'd8);
            if (k == 8) check("swish_note0_hold", 32'(note_o), 32'd8);
            if (k == 9) check("swish_second_note", 32'(note_o), 32'd13);
            if (k == 17) check("swish_third_note", 32'(note_o), 32'd20);
            if (k == 32) check("swish_busy_before_end", 32'(busy_o), 32'd1);
            if (k == 33) check("swish_done", 32'(done_o), 32'd1);
            if (k == 33) check("swish_silence", 32'(note_o), 32'd31);
            if (k == 34) check("swish_done_one_cycle", 32'(done_o), 32'd0);
        end
        // Hit preempts swish
        cyc(3'b001, 1'b1);
        for (int k = 1; k < 5; k++) cyc(3'b000, 1'b1);
        cyc(3'b100, 1'b1);
        cyc(3'b000, 1'b1);
        check("preempt_aborted", 32'(aborted_o), 32'd1);
        check("preempt_note", 32'(note_o), 32'd3);
        check("preempt_id", 32'(active_id_o), 32'd2);
        for (int k = 0; k < 30; k++) cyc(3'b000, 1'b1);
        // Swoosh queued behind hit
        cyc(3'b100, 1'b1);
        for (int k = 0; k < 5; k++) cyc(3'b000, 1'b1);
        cyc(3'b010, 1'b1);
        for (int k = 0; k < 40; k++) cyc(3'b000, 1'b1);
        // Simultaneous swish and swoosh
        cyc(3'b011, 1'b1);
        cyc(3'b000, 1'b1);
        check("simul_swoosh_first", 32'(active_id_o), 32'd1);
        for (int k = 0; k < 80; k++) cyc(3'b000, 1'b1);
        // Reset during swoosh step 2 drops a pending swish
        cyc(3'b010, 1'b1);
        for (int k = 1; k < 10; k++) cyc(3'b000, 1'b1);
        cyc(3'b001, 1'b1);
        cyc(3'b000, 1'b0);
        check("reset_note", 32'(note_o), 32'd31);
        check("reset_no_done", 32'(done_o), 32'd0);
        for (int k = 0; k < 10; k++) cyc(3'b000, 1'b1);
        check("reset_pending_lost", 32'(busy_o), 32'd0);
        // Random requests with occasional reset
        r = 3'b000;
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(5) == 0) r[b] = ~r[b];
            rst = ($urandom_range(299) != 0);
            cyc(r, rst);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer and arbiter that drives the 5-bit `note` input of `pwm_gen`. Three game-event requesters (swish, swoosh, hit) each trigger a short hard-coded melody. The block picks one requester by fixed priority, with preemption, and steps through that melody's notes on a programmable time base. It sits between the game-logic FSM and `pwm_gen` in the same `clk` domain.

## Interface
- `TICK_CYCLES`, default 6_250_000: `clk` cycles per duration unit (62.5 ms at 100 MHz). Benches use 4.
- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  synchronous, active-low; all state is cleared on any edge where `reset`=0
- `req`  in  3  sound requests; `req[2]`=hit (highest priority), `req[1]`=swoosh, `req[0]`=swish. Rising-edge sensitive.
- `note`  out  5  note index to `pwm_gen`; 31 = silence
- `busy`  out  1  a sequence is playing
- `active_id`  out  2  index of the sequence playing; valid while `busy`=1
- `done`  out  1  one-cycle pulse when a sequence finishes naturally
- `aborted`  out  1  one-cycle pulse when a sequence is preempted

## Operation
- Reset values: `note`=31, `busy`=0, `active_id`=0, `done`=0, `aborted`=0. Pending bits, step index, prescaler and unit counter all clear to 0. Internal `req_q` clears to 0.
- Edge detect: `rise = req & ~req_q`; `req_q <= req` every cycle.
- Each `rise[i]` sets `pending[i]`. Exceptions:
  - `busy`=1 and i==`active_id`: ignored (no retrigger).
  - Other rises are handled by the preemption and queueing rules below.
- Sequence ROM: 9-bit steps {last, note[4:0], len[2:0]}. Step duration is exactly (len+1)×`TICK_CYCLES` cycles.
  - seq0 swish: (8,len1), (13,len1), (20,len3,last). Total 8 units.
  - seq1 swoosh: (25,len0), (22,len0), (17,len0), (13,len0), (8,len3,last). Total 8 units.
  - seq2 hit: (3,len0), (31,len0), (3,len1,last). Total 4 units. Note 31 here is a rest.
- FSM states: IDLE, PLAY.
  - IDLE, `pending`≠0: grant the highest set bit i. Clear `pending[i]`, set step=0, `note`=step0 note, `busy`=1, `active_id`=i. Prescaler and unit counter reset to 0. Go to PLAY.
  - PLAY, prescaler reaches `TICK_CYCLES`-1: prescaler wraps to 0 and the unit counter increments.
  - PLAY, unit counter reaches len on that wrap, step not last: step+1, load next note, unit counter cleared.
  - PLAY, unit counter reaches len on that wrap, step is last: `note`=31, `busy`=0, `done`=1, go to IDLE.
  - PLAY, `pending[j]` set with j>`active_id`: preempt. Reload step0 of j, clear `pending[j]`, set `aborted`=1, reset the timers. The old sequence is dropped and not re-queued. Preemption takes precedence over step advance in the same cycle.
  - PLAY, `pending[j]` set with j<`active_id`: held until the current sequence ends.
- Simultaneous rises: all corresponding pending bits set; the highest bit wins the next grant.

## Timing
- A `rise` sampled at edge E0 sets `pending` at E0. The grant or preemption happens at E1, so `note`/`busy`/`active_id` change at E1: 2 edges after the first sampled high `req`.
- The first note is held for exactly (len0+1)×`TICK_CYCLES` cycles from E1. Subsequent note changes fall exactly on step boundaries.
- Natural completion forces a one-cycle IDLE with `note`=31 and `done`=1, even when a grant is pending. The queued grant follows on the next edge.
- `done` and `aborted` are never both high. Neither pulses on reset.
- `reset`=0 mid-sequence: on the next edge all outputs return to reset values, `pending` clears, and no `done` is produced.
- Prescaler width is ceil(log2(`TICK_CYCLES`)). The unit counter is 3 bits, the step index 3 bits.

## Test plan (TICK_CYCLES=4)
- Hold reset for 3 cycles, then release with no `req` → `note`=31, `busy`=0, no pulses for 50 cycles.
- Pulse `req[0]` at edge 0 → `note` goes 8 at edge 1 (8 cycles), then 13 (8 cycles), then 20 (16 cycles). Then `note`=31 with a `done` pulse at edge 33, and `busy` low from edge 33.
- Start `req[0]`, then rise `req[2]` 5 cycles later → `aborted` pulses and `note`=3 two edges after the rise. `active_id`=2, hit plays for 16 cycles, then `done`; swish does not resume.
- Play `req[2]` and rise `req[1]` mid-sequence → hit completes untouched. One idle cycle follows with `done`, then `note`=25, `active_id`=1.
- Rise `req[0]` and `req[1]` in the same cycle → swoosh plays first. After its `done` plus one idle cycle, swish starts.
- Assert reset low during step 2 of swoosh → next edge `note`=31, `busy`=0, `done`=0. A previously pending `req[0]` is lost.
